// File: rtl/filt_chain_pkg.sv
// filt_chain_pkg: width helpers and saturation shared by the CIC+FIR chain.
package filt_chain_pkg;
  function automatic int cic_width(input int data_w, input int order, input int max_dec_log2);
    return data_w + order * max_dec_log2;
  endfunction
  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps) + 1;
  endfunction
  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/cic_decim.sv
// cic_decim: order-N CIC decimator, power-of-two ratio, unity-gain scaling and bypass.
module cic_decim
  import filt_chain_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CIC_ORDER    = 2,
  parameter int MAX_DEC_LOG2 = 3
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 clr_i,
  input  logic                                 valid_i,
  input  logic                                 cic_en_i,
  input  logic [$clog2(MAX_DEC_LOG2+1)-1:0]    dec_log2_i,
  input  logic signed [DATA_W-1:0]             data_i,
  output logic signed [DATA_W-1:0]             data_o,
  output logic                                 valid_o
);
  localparam int CW  = cic_width(DATA_W, CIC_ORDER, MAX_DEC_LOG2);
  localparam int DLW = $clog2(MAX_DEC_LOG2 + 1);
  logic signed [CW-1:0] integ_q [CIC_ORDER];
  logic signed [CW-1:0] integ_d [CIC_ORDER];
  logic signed [CW-1:0] dly_q [CIC_ORDER];
  logic signed [CW-1:0] dly_d [CIC_ORDER];
  logic signed [CW-1:0] comb [CIC_ORDER+1];
  logic signed [CW-1:0] scaled;
  logic [MAX_DEC_LOG2-1:0] cnt_q, cnt_d, lim;
  logic [DLW-1:0] dl;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic valid_q, valid_d, acc_en, fire;

  // Integrators cascade combinationally so the comb sees the frame's last sample.
  always_comb begin
    dl = dec_log2_i > DLW'(MAX_DEC_LOG2) ? DLW'(MAX_DEC_LOG2) : dec_log2_i;
    lim = ~({MAX_DEC_LOG2{1'b1}} << dl);
    acc_en = cic_en_i && valid_i;
    fire = acc_en && cnt_q >= lim;
    cnt_d = acc_en ? (fire ? '0 : cnt_q + 1'b1) : cnt_q;
    integ_d[0] = integ_q[0] + CW'(data_i);
    for (int k = 1; k < CIC_ORDER; k++) integ_d[k] = integ_q[k] + integ_d[k-1];
    comb[0] = integ_d[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) begin
      comb[k+1] = comb[k] - dly_q[k];
      dly_d[k] = fire ? comb[k] : dly_q[k];
    end
    scaled = comb[CIC_ORDER] >>> (CIC_ORDER * int'(dl));
    valid_d = cic_en_i ? fire : valid_i;
    out_d = !cic_en_i ? (valid_i ? data_i : out_q) : (fire ? DATA_W'(scaled) : out_q);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      integ_q <= '{default: '0};
      dly_q   <= '{default: '0};
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      integ_q <= '{default: '0};
      dly_q   <= '{default: '0};
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (acc_en) integ_q <= integ_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end

  assign data_o  = out_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/filt_chain.sv
// filt_chain: CIC decimator followed by a shift-scaled, saturating NTAPS FIR.
module filt_chain
  import filt_chain_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int COEF_W       = 8,
  parameter int NTAPS        = 3,
  parameter int CIC_ORDER    = 2,
  parameter int MAX_DEC_LOG2 = 3
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 data_ready,
  input  logic signed [DATA_W-1:0]             data_in,
  input  logic                                 cic_en,
  input  logic                                 fir_en,
  input  logic                                 clr,
  input  logic [$clog2(MAX_DEC_LOG2+1)-1:0]    dec_log2,
  input  logic [NTAPS*COEF_W-1:0]              coefs,
  input  logic [3:0]                           shift,
  output logic signed [DATA_W-1:0]             data_filtered,
  output logic                                 filtered_ready,
  output logic                                 sat_flag
);
  localparam int AW = acc_width(DATA_W, COEF_W, NTAPS);
  logic signed [DATA_W-1:0] cic_out, y_q, y_d;
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [DATA_W-1:0] x_d [NTAPS];
  logic signed [AW-1:0] acc, sh;
  logic signed [63:0] sat_v;
  logic cic_valid, rdy_q, sat_q, sat_d, clip;

  cic_decim #(
    .DATA_W(DATA_W), .CIC_ORDER(CIC_ORDER), .MAX_DEC_LOG2(MAX_DEC_LOG2)
  ) u_cic (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .valid_i(data_ready), .cic_en_i(cic_en),
    .dec_log2_i(dec_log2), .data_i(data_in), .data_o(cic_out), .valid_o(cic_valid)
  );

  // Sum over the line as it will be after this strobe's shift, so output lands next edge.
  always_comb begin
    x_d[0] = cic_out;
    for (int k = 1; k < NTAPS; k++) x_d[k] = x_q[k-1];
    acc = '0;
    for (int k = 0; k < NTAPS; k++)
      acc += AW'($signed(coefs[k*COEF_W +: COEF_W])) * AW'(x_d[k]);
    sh = acc >>> shift;
    sat_v = saturate(64'(sh), DATA_W);
    clip = sat_v != 64'(sh);
    y_d = !cic_valid ? y_q : (fir_en ? DATA_W'(sat_v) : cic_out);
    sat_d = sat_q | (cic_valid & fir_en & clip);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x_q   <= '{default: '0};
      y_q   <= '0;
      rdy_q <= 1'b0;
      sat_q <= 1'b0;
    end else if (clr) begin
      x_q   <= '{default: '0};
      y_q   <= '0;
      rdy_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      if (cic_valid) x_q <= x_d;
      y_q   <= y_d;
      rdy_q <= cic_valid;
      sat_q <= sat_d;
    end

  assign data_filtered  = y_q;
  assign filtered_ready = rdy_q;
  assign sat_flag       = sat_q;
endmodule

// File: tb/tb_filt_chain.sv
// tb_filt_chain: vector tables drive filt_chain; a timestamped scoreboard checks value and latency.
module tb_filt_chain;
  logic clk = 1'b0, reset_n = 1'b0, data_ready = 1'b0, cic_en = 1'b0, fir_en = 1'b0, clr = 1'b0;
  logic signed [7:0] data_in = '0;
  logic [1:0] dec_log2 = '0;
  logic [23:0] coefs = '0;
  logic [3:0] shift = '0;
  logic signed [7:0] data_filtered;
  logic filtered_ready, sat_flag;

  typedef struct {logic dr; int din; logic ev; int val;} vec_t;
  typedef struct {int cyc; int val;} exp_t;
  vec_t vt[$];
  exp_t sb[$];
  int cyc = 0, total = 0, passed = 0;

  filt_chain dut (
    .clk(clk), .reset_n(reset_n), .data_ready(data_ready), .data_in(data_in),
    .cic_en(cic_en), .fir_en(fir_en), .clr(clr), .dec_log2(dec_log2), .coefs(coefs),
    .shift(shift), .data_filtered(data_filtered), .filtered_ready(filtered_ready),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (filtered_ready) begin
      if (sb.size() == 0) chk("unexpected_ready", int'(filtered_ready), 0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("data_filtered", int'(data_filtered), e.val);
      end
    end
  end

  task automatic add(input logic dr, input int din, input logic ev, input int val);
    vec_t v;
    v.dr = dr; v.din = din; v.ev = ev; v.val = val;
    vt.push_back(v);
  endtask

  task automatic drive(input logic dr, input int din, input logic ev, input int val);
    exp_t e;
    @(negedge clk);
    data_ready = dr;
    data_in = 8'(din);
    if (ev) begin
      e.cyc = cyc + 2;
      e.val = val;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    data_ready = 1'b0;
    repeat (n) @(negedge clk);
    chk("pending_outputs", sb.size(), 0);
  endtask

  task automatic apply();
    foreach (vt[i]) drive(vt[i].dr, vt[i].din, vt[i].ev, vt[i].val);
    vt.delete();
    idle(4);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    data_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic phase_bypass();
    cic_en = 1'b0; fir_en = 1'b0; coefs = '0; shift = '0; dec_log2 = '0;
    add(1, 5, 1, 5); add(0, 0, 0, 0); add(0, 0, 0, 0); add(1, -7, 1, -7); add(1, 127, 1, 127);
    apply();
    chk("bypass_sat", int'(sat_flag), 0);
  endtask

  task automatic phase_decim();
    int e[3];
    e = '{6, 10, 10};
    cic_en = 1'b1; fir_en = 1'b0; dec_log2 = 2'd2;
    for (int i = 0; i < 12; i++) add(1, 10, i % 4 == 3, e[i/4]);
    apply();
  endtask

  initial begin
    int e[4];
    repeat (2) @(negedge clk);
    chk("reset_data", int'(data_filtered), 0);
    chk("reset_ready", int'(filtered_ready), 0);
    chk("reset_sat", int'(sat_flag), 0);
    reset_n = 1'b1;
    phase_bypass();
    phase_decim();
    // CIC then FIR {1,2,1} with >>>2
    do_clr();
    fir_en = 1'b1; coefs = {8'd1, 8'd2, 8'd1}; shift = 4'd2;
    e = '{1, 5, 9, 10};
    for (int i = 0; i < 16; i++) add(1, 10, i % 4 == 3, e[i/4]);
    apply();
    chk("fir_sat", int'(sat_flag), 0);
    // R=1: every sample passes through the CIC unchanged
    do_clr();
    fir_en = 1'b0; dec_log2 = 2'd0;
    add(1, 3, 1, 3); add(1, -4, 1, -4); add(1, 50, 1, 50); add(1, -128, 1, -128);
    apply();
    // saturation in both directions
    do_clr();
    cic_en = 1'b0; fir_en = 1'b1; coefs = {3{8'd127}}; shift = 4'd0;
    for (int i = 0; i < 3; i++) add(1, 100, 1, 127);
    add(1, -128, 1, 127); add(1, -128, 1, -128); add(1, -128, 1, -128);
    apply();
    chk("sat_set", int'(sat_flag), 1);
    // shift rounds toward -inf; sat_flag stays sticky
    coefs = 24'h000001; shift = 4'd1;
    add(1, -3, 1, -2); add(1, 5, 1, 2);
    apply();
    chk("sat_sticky", int'(sat_flag), 1);
    // clr two samples into an R=4 frame drops the coincident sample
    cic_en = 1'b1; fir_en = 1'b0; dec_log2 = 2'd2;
    add(1, 10, 0, 0); add(1, 10, 0, 0);
    apply();
    @(negedge clk);
    clr = 1'b1; data_ready = 1'b1; data_in = 8'sd10;
    @(negedge clk);
    clr = 1'b0; data_ready = 1'b0;
    chk("clr_sat", int'(sat_flag), 0);
    add(1, 10, 0, 0); add(1, 10, 0, 0); add(1, 10, 0, 0); add(1, 10, 1, 6);
    apply();
    // reset mid-frame with sat_flag set and a held output
    do_clr();
    fir_en = 1'b1; coefs = {3{8'd127}}; shift = 4'd0;
    for (int i = 0; i < 10; i++) drive(1, 100, i == 3 || i == 7, 127);
    @(posedge clk);
    #3;
    chk("pre_reset_outputs", sb.size(), 0);
    chk("pre_reset_data", int'(data_filtered), 127);
    chk("pre_reset_sat", int'(sat_flag), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_data", int'(data_filtered), 0);
    chk("async_reset_ready", int'(filtered_ready), 0);
    chk("async_reset_sat", int'(sat_flag), 0);
    data_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    phase_bypass();
    phase_decim();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
